ram_responder: RTL and testbench

//  RAM-side responder for the ramREN/ramWEN/ramaddr/ramstore -> ramload/ramstate interface driven by the memory

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/ram_array.sv | 32 +++
 rtl/ram_responder.sv | 162 ++++++++++++++++
 tb/tb_ram_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types.
//   word_t     : 32-bit data word
//   ramstate_t : RAM responder status seen by the memory arbiter
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/ram_array.sv
// Word-addressed storage: DEPTH x 32-bit, asynchronous read, synchronous write.
// Ports:
//   i_clk   : clock, rising edge
//   i_wen   : write enable
//   i_widx  : write word index
//   i_wdata : write data
//   i_ridx  : read word index
//   o_rdata : read data (combinational)
module ram_array #(
    parameter int unsigned DEPTH  = 16384,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wen,
    input  logic [ADDR_W-1:0] i_widx,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_ridx,
    output logic [31:0]       o_rdata
);
    import cpu_types_pkg::*;

    word_t r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wen) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/ram_responder.sv
// RAM-side responder for the arbiter's ramREN/ramWEN/ramaddr/ramstore interface.
// Models main memory with LAT BUSY cycles before a single ACCESS cycle; a change of the live
// request while BUSY restarts the countdown.
// Ports:
//   CLK      : clock, rising edge
//   RST      : synchronous active-high reset
//   ramREN   : read request
//   ramWEN   : write request (wins over ramREN)
//   ramaddr  : byte address, word index = ramaddr[ADDR_W+1:2]
//   ramstore : write data
//   ramload  : read data, valid in ACCESS, else 0
//   ramstate : registered ramstate_t status
// Configuration: define RAM_RANGE_ERR_EN to report out-of-range addresses with ERROR;
// otherwise addresses wrap modulo DEPTH words.
module ram_responder #(
    parameter int unsigned LAT   = 2,
    parameter int unsigned DEPTH = 16384
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);
    import cpu_types_pkg::*;

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

    typedef enum logic [1:0] {
        StFree,
        StBusy,
        StAccess,
        StError
    } state_t;

    state_t            r_state, w_state_d;
    logic [CNT_W-1:0]  r_cnt, w_cnt_d;
    logic              r_op, w_op_d;      // 1 = write
    logic [ADDR_W-1:0] r_idx, w_idx_d;
    word_t             r_data, w_data_d;
    logic              r_err, w_err_d;

    logic              w_req;
    logic              w_op;
    logic [ADDR_W-1:0] w_idx;
    logic              w_err;
    logic              w_match;
    logic              w_wen;
    word_t             w_rdata;
    logic              w_unused_bits;

    assign w_req = ramREN | ramWEN;
    assign w_op  = ramWEN;
    assign w_idx = ramaddr[ADDR_W+1:2];

`ifdef RAM_RANGE_ERR_EN
    assign w_err = |ramaddr[31:ADDR_W+2];
`else
    assign w_err = 1'b0;
`endif

    assign w_unused_bits = ^{ramaddr[1:0], ramaddr[31:ADDR_W+2]};

    // Data is deliberately excluded: a ramstore change must not restart the access.
    assign w_match = (w_op == r_op) && (w_idx == r_idx) && (w_err == r_err);

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_op_d    = r_op;
        w_idx_d   = r_idx;
        w_data_d  = r_data;
        w_err_d   = r_err;
        w_wen     = 1'b0;
        unique case (r_state)
            StFree: begin
                if (w_req) begin
                    w_op_d    = w_op;
                    w_idx_d   = w_idx;
                    w_data_d  = ramstore;
                    w_err_d   = w_err;
                    w_cnt_d   = CNT_INIT;
                    w_state_d = StBusy;
                end
            end
            StBusy: begin
                if (!w_req) begin
                    w_state_d = StFree;
                end else begin
                    w_data_d = ramstore;
                    if (!w_match) begin
                        w_op_d  = w_op;
                        w_idx_d = w_idx;
                        w_err_d = w_err;
                        w_cnt_d = CNT_INIT;
                    end else if (r_cnt == '0) begin
                        w_state_d = r_err ? StError : StAccess;
                    end else begin
                        w_cnt_d = r_cnt - 1'b1;
                    end
                end
            end
            StAccess: begin
                w_wen     = r_op && w_req && w_match;
                w_state_d = StFree;
            end
            StError: begin
                w_state_d = StFree;
            end
            default: w_state_d = StFree;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= StFree;
            r_cnt   <= '0;
            r_op    <= 1'b0;
            r_idx   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_op    <= w_op_d;
            r_idx   <= w_idx_d;
            r_data  <= w_data_d;
            r_err   <= w_err_d;
        end
    end

    // Reset during ACCESS must suppress the commit.
    ram_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .i_clk   (CLK),
        .i_wen   (w_wen & ~RST),
        .i_widx  (r_idx),
        .i_wdata (r_data),
        .i_ridx  (r_idx),
        .o_rdata (w_rdata)
    );

    assign ramload = (r_state == StAccess) ? w_rdata : '0;

    always_comb begin
        ramstate = FREE;
        unique case (r_state)
            StFree:   ramstate = FREE;
            StBusy:   ramstate = BUSY;
            StAccess: ramstate = ACCESS;
            StError:  ramstate = ERROR;
            default:  ramstate = FREE;
        endcase
    end

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder (LAT=2, DEPTH=1024). Honours RAM_RANGE_ERR_EN.
module tb_ram_responder;
    import cpu_types_pkg::*;

    localparam int unsigned LAT    = 2;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic [31:0] ram_load;
    logic [1:0]  ram_state;

    typedef struct packed {
        logic [1:0]  st;
        logic [31:0] load;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [DEPTH];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          mon_en = 1'b0;

    ram_responder #(
        .LAT   (LAT),
        .DEPTH (DEPTH)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .ramREN   (ram_ren),
        .ramWEN   (ram_wen),
        .ramaddr  (ram_addr),
        .ramstore (ram_store),
        .ramload  (ram_load),
        .ramstate (ram_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every ACCESS/ERROR cycle pops one expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ram_state == ACCESS || ram_state == ERROR) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected", {30'b0, ram_state}, {30'b0, FREE});
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_state", {30'b0, ram_state}, {30'b0, e.st});
                    check("sb_load", ram_load, e.load);
                end
            end else begin
                check("load_idle", ram_load, 32'h0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ram_ren = 1'b0;
        ram_wen = 1'b0;
    endtask

    task automatic expect_state(input string tag, input ramstate_t st);
        @(negedge clk);
        check(tag, {30'b0, ram_state}, {30'b0, st});
    endtask

    function automatic int widx(input logic [31:0] addr);
        return int'((addr >> 2) % DEPTH);
    endfunction

    function automatic bit addr_err(input logic [31:0] addr);
`ifdef RAM_RANGE_ERR_EN
        return (addr >> (ADDR_W + 2)) != 0;
`else
        return (addr == 32'hFFFF_FFFF) && (addr != 32'hFFFF_FFFF);
`endif
    endfunction

    // Full transaction with cycle-exact timing checks; request is held through the ACCESS edge.
    task automatic txn(input bit wr, input bit both, input logic [31:0] addr,
                       input logic [31:0] data);
        int idx;
        bit err;
        idx = widx(addr);
        err = addr_err(addr);
        step();
        sb_q.push_back(err ? exp_t'{st: ERROR, load: 32'h0} : exp_t'{st: ACCESS, load: model[idx]});
        ram_wen   = wr;
        ram_ren   = !wr || both;
        ram_addr  = addr;
        ram_store = data;
        expect_state("c0_free", FREE);
        for (int c = 1; c <= int'(LAT); c++) begin
            step();
            expect_state("busy", BUSY);
        end
        step();
        expect_state("term", err ? ERROR : ACCESS);
        step();
        idle();
        if (wr && !err) model[idx] = data;
        expect_state("back_free", FREE);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] pre_addr [6];
        pre_addr = '{32'h0, 32'h40, 32'h80, 32'h10, 32'h100, 32'h200};

        // Reset held with a pending read request.
        rst = 1'b1; ram_ren = 1'b1; ram_wen = 1'b0; ram_addr = 32'h100; ram_store = 32'h0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        expect_state("rst_free0", FREE);
        step();
        expect_state("rst_free1", FREE);
        step();
        rst = 1'b0;
        idle();
        expect_state("rst_release", FREE);

        // Preload every location the tests read.
        for (int i = 0; i < 6; i++) begin
            txn(1'b1, 1'b0, pre_addr[i], 32'hA000_0000 + 32'(i));
        end

        // Write then read back.
        txn(1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF);
        txn(1'b0, 1'b0, 32'h100, 32'h0);

        // ramstore change mid-BUSY updates the committed data without restart.
        step();
        sb_q.push_back(exp_t'{st: ACCESS, load: model[widx(32'h100)]});
        ram_wen = 1'b1; ram_addr = 32'h100; ram_store = 32'h1111_1111;
        expect_state("st_c0", FREE);
        step();
        ram_store = 32'h2222_2222;
        expect_state("st_busy1", BUSY);
        step();
        expect_state("st_busy2", BUSY);
        step();
        expect_state("st_access", ACCESS);
        step();
        idle();
        model[widx(32'h100)] = 32'h2222_2222;
        expect_state("st_free", FREE);
        txn(1'b0, 1'b0, 32'h100, 32'h0);

        // Restart: switch from RD 0x040 to RD 0x200 while BUSY with cnt=1.
        step();
        ram_ren = 1'b1; ram_addr = 32'h40;
        expect_state("rs_c0", FREE);
        step();
        ram_addr = 32'h200;
        sb_q.push_back(exp_t'{st: ACCESS, load: model[widx(32'h200)]});
        expect_state("rs_busy1", BUSY);
        step();
        expect_state("rs_busy2", BUSY);
        step();
        expect_state("rs_busy3", BUSY);
        step();
        expect_state("rs_access", ACCESS);
        step();
        idle();
        expect_state("rs_free", FREE);

        // Abort by dropping ramWEN in BUSY.
        step();
        ram_wen = 1'b1; ram_addr = 32'h80; ram_store = 32'h1234;
        expect_state("ab_c0", FREE);
        step();
        expect_state("ab_busy1", BUSY);
        step();
        idle();
        expect_state("ab_busy2", BUSY);
        step();
        expect_state("ab_free", FREE);
        txn(1'b0, 1'b0, 32'h80, 32'h0);

        // Abort by reset in the ACCESS cycle.
        step();
        ram_wen = 1'b1; ram_addr = 32'h80; ram_store = 32'h9999;
        sb_q.push_back(exp_t'{st: ACCESS, load: model[widx(32'h80)]});
        expect_state("ra_c0", FREE);
        for (int c = 1; c <= int'(LAT); c++) begin
            step();
            expect_state("ra_busy", BUSY);
        end
        step();
        rst = 1'b1;
        expect_state("ra_access", ACCESS);
        step();
        rst = 1'b0;
        idle();
        expect_state("ra_free", FREE);
        txn(1'b0, 1'b0, 32'h80, 32'h0);

        // Both strobes high: write wins.
        txn(1'b1, 1'b1, 32'h10, 32'h5);
        txn(1'b0, 1'b0, 32'h10, 32'h0);

        // Out-of-range address: ERROR with the macro, alias of word 0 without.
        txn(1'b0, 1'b0, 32'h0000_1000, 32'h0);

        step();
        mon_en = 1'b0;
        check("sb_drain", 32'(sb_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
